// File: rtl/drop_statemachine.sv
// drop_statemachine: board-write engine for the Connect4 datapath.
// Accepts a drop request and scans the chosen column upward from row 0 in
// the board RAM. The player's token goes into the first empty cell, then
// finished is pulsed. A full column finishes with col_full set and no write.
// Optional feature macro DROP_COL_CHECK_EN: when defined, a column >= COLS is
// rejected straight away, with no RAM access. When the macro is undefined,
// any 3-bit column is scanned.
module drop_statemachine #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        drop_en,
    input  logic [2:0]  col,
    input  logic        player,
    input  logic [15:0] ram_r_val,
    output logic [2:0]  drop_addr,
    output logic        drop_r_en,
    output logic        drop_w_en,
    output logic [15:0] ram_w_val,
    output logic [2:0]  placed_row,
    output logic        col_full,
    output logic        finished
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    // Reject out-of-range geometry at elaboration.
    if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8) begin : g_bad_geometry
        $error("drop_statemachine: ROWS and COLS must lie in 1..8");
    end

`ifdef DROP_COL_CHECK_EN
    localparam logic [3:0] COLS_LIM = 4'(COLS);
`endif

    logic [2:0] state;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic       player_q;

    // Token encoding for each player.
    function automatic logic [1:0] token_of(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Two-bit cell of column c within a RAM row word.
    function automatic logic [1:0] cell_of(input logic [15:0] w, input logic [2:0] c);
        logic [15:0] s;
        s = w >> {c, 1'b0};
        return s[1:0];
    endfunction

    // Row word with column c replaced by token t, all other cells untouched.
    function automatic logic [15:0] place_token(input logic [15:0] w, input logic [2:0] c,
                                                input logic [1:0] t);
        logic [15:0] m;
        logic [15:0] v;
        m = 16'h0003 << {c, 1'b0};
        v = {14'b0, t} << {c, 1'b0};
        return (w & ~m) | v;
    endfunction

    // Control FSM with registered RAM strobes and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            player_q   <= 1'b0;
            drop_addr  <= 3'd0;
            drop_r_en  <= 1'b0;
            drop_w_en  <= 1'b0;
            ram_w_val  <= 16'h0000;
            placed_row <= 3'd0;
            col_full   <= 1'b0;
            finished   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (drop_en) begin
                        col_q    <= col;
                        player_q <= player;
                        row_q    <= 3'd0;
                        col_full <= 1'b0;
                        finished <= 1'b0;
`ifdef DROP_COL_CHECK_EN
                        if ({1'b0, col} >= COLS_LIM) begin
                            // Illegal column: finish at once as a rejected drop.
                            col_full <= 1'b1;
                            finished <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            drop_addr <= 3'd0;
                            drop_r_en <= 1'b1;
                            state     <= S_READ;
                        end
`else
                        drop_addr <= 3'd0;
                        drop_r_en <= 1'b1;
                        state     <= S_READ;
`endif
                    end
                end
                S_READ: begin
                    // RAM captures the address on this edge; data is ready in EVAL.
                    drop_r_en <= 1'b0;
                    state     <= S_EVAL;
                end
                S_EVAL: begin
                    if (cell_of(ram_r_val, col_q) == 2'b00) begin
                        ram_w_val  <= place_token(ram_r_val, col_q, token_of(player_q));
                        drop_w_en  <= 1'b1;
                        placed_row <= row_q;
                        state      <= S_WRITE;
                    end else if (row_q != LAST_ROW) begin
                        row_q     <= row_q + 3'd1;
                        drop_addr <= row_q + 3'd1;
                        drop_r_en <= 1'b1;
                        state     <= S_READ;
                    end else begin
                        col_full <= 1'b1;
                        finished <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_WRITE: begin
                    drop_w_en <= 1'b0;
                    finished  <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // finished was raised on entry; col_full is held until next accept.
                    finished <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    drop_r_en <= 1'b0;
                    drop_w_en <= 1'b0;
                    finished  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_statemachine.sv
// Testbench for drop_statemachine: directed drops against a behavioural
// board RAM with one-cycle read latency.
module tb_drop_statemachine;

    logic        clk;
    logic        rst_n;
    logic        drop_en;
    logic [2:0]  col;
    logic        player;
    logic [15:0] ram_r_val;
    logic [2:0]  drop_addr;
    logic        drop_r_en;
    logic        drop_w_en;
    logic [15:0] ram_w_val;
    logic [2:0]  placed_row;
    logic        col_full;
    logic        finished;

    logic [15:0] mem [0:7];

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          rd_cnt;
    int          wr_cnt;
    int          fin_cnt;
    int          fin_cyc;
    logic        fin_full;
    logic [23:0] rd_addrs;
    logic [2:0]  wr_addr;
    logic [15:0] wr_val;

    drop_statemachine #(.ROWS(6), .COLS(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drop_en    (drop_en),
        .col        (col),
        .player     (player),
        .ram_r_val  (ram_r_val),
        .drop_addr  (drop_addr),
        .drop_r_en  (drop_r_en),
        .drop_w_en  (drop_w_en),
        .ram_w_val  (ram_w_val),
        .placed_row (placed_row),
        .col_full   (col_full),
        .finished   (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM read port: one-cycle registered read.
    always @(posedge clk) begin
        if (drop_r_en) ram_r_val <= mem[drop_addr];
    end

    // Bus monitor: logs strobes and completion with the edge index they were seen at.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (drop_r_en) begin
            rd_cnt   = rd_cnt + 1;
            rd_addrs = {rd_addrs[20:0], drop_addr};
        end
        if (drop_w_en) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = drop_addr;
            wr_val  = ram_w_val;
        end
        if (finished) begin
            fin_cnt  = fin_cnt + 1;
            fin_cyc  = cyc;
            fin_full = col_full;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                            input logic [15:0] rest);
        mem[0] = r0;
        mem[1] = r1;
        mem[2] = r2;
        for (int i = 3; i < 8; i++) mem[i] = rest;
    endtask

    // Present a request and return the index of the accepting edge.
    task automatic do_drop(input logic [2:0] c, input logic p, output int a);
        drop_en = 1'b1;
        col     = c;
        player  = p;
        @(posedge clk);
        #1;
        a       = cyc;
        drop_en = 1'b0;
    endtask

    // Wait (bounded) for the completion pulse.
    task automatic wait_fin(input string tag, input int fin_base);
        int n;
        n = 0;
        while (fin_cnt == fin_base && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_fin_count"}, fin_cnt - fin_base, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_drop_addr"}, {29'b0, drop_addr}, 0);
        chk({tag, "_placed_row"}, {29'b0, placed_row}, 0);
        chk({tag, "_ram_w_val"}, {16'b0, ram_w_val}, 0);
        chk({tag, "_strobes"}, {28'b0, drop_r_en, drop_w_en, col_full, finished}, 0);
    endtask

    initial begin
        int a;
        int rb;
        int wb;
        int fb;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        fin_cnt   = 0;
        fin_cyc   = 0;
        fin_full  = 1'b0;
        rd_addrs  = '0;
        wr_addr   = '0;
        wr_val    = '0;
        ram_r_val = 16'h0000;
        rst_n     = 1'b0;
        drop_en   = 1'b0;
        col       = 3'd0;
        player    = 1'b0;
        fill_mem(16'h0000, 16'h0000, 16'h0000, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty board, bottom-row drop.
        rb = rd_cnt; wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd3, 1'b0, a);
        wait_fin("t1", fb);
        chk("t1_reads", rd_cnt - rb, 1);
        chk("t1_writes", wr_cnt - wb, 1);
        chk("t1_wr_addr", {29'b0, wr_addr}, 0);
        chk("t1_wr_val", {16'b0, wr_val}, 32'h0040);
        chk("t1_placed_row", {29'b0, placed_row}, 0);
        chk("t1_latency", fin_cyc - a, 4);
        chk("t1_col_full", {31'b0, fin_full}, 0);

        // Column 3 occupied in rows 0..1, player 1.
        fill_mem(16'h0080, 16'h0040, 16'h0000, 16'h0000);
        rb = rd_cnt; wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd3, 1'b1, a);
        wait_fin("t2", fb);
        chk("t2_reads", rd_cnt - rb, 3);
        chk("t2_rd_addrs", {23'b0, rd_addrs[8:0]}, {23'b0, 3'd0, 3'd1, 3'd2});
        chk("t2_writes", wr_cnt - wb, 1);
        chk("t2_wr_addr", {29'b0, wr_addr}, 2);
        chk("t2_wr_val", {16'b0, wr_val}, 32'h0080);
        chk("t2_placed_row", {29'b0, placed_row}, 2);
        chk("t2_latency", fin_cyc - a, 8);

        // Column 0 full.
        fill_mem(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        rb = rd_cnt; wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd0, 1'b0, a);
        wait_fin("t3", fb);
        chk("t3_reads", rd_cnt - rb, 6);
        chk("t3_rd_last", {29'b0, rd_addrs[2:0]}, 5);
        chk("t3_writes", wr_cnt - wb, 0);
        chk("t3_latency", fin_cyc - a, 13);
        chk("t3_col_full_at_fin", {31'b0, fin_full}, 1);
        chk("t3_col_full_hold", {31'b0, col_full}, 1);

        // Neighbour preservation.
        fill_mem(16'h2AA8, 16'h0000, 16'h0000, 16'h0000);
        wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd0, 1'b0, a);
        chk("t4_col_full_cleared", {31'b0, col_full}, 0);
        wait_fin("t4", fb);
        chk("t4_writes", wr_cnt - wb, 1);
        chk("t4_wr_val", {16'b0, wr_val}, 32'h2AA9);

        // Reset asserted in the cycle before drop_w_en would rise.
        fill_mem(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd2, 1'b0, a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_async");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_write", wr_cnt - wb, 0);
        chk("t5_no_fin", fin_cnt - fb, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_idle_no_write", wr_cnt - wb, 0);
        wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd2, 1'b1, a);
        wait_fin("t5_after", fb);
        chk("t5_after_writes", wr_cnt - wb, 1);
        chk("t5_after_wr_val", {16'b0, wr_val}, 32'h0020);
        chk("t5_after_latency", fin_cyc - a, 4);

        // Column 7.
        fill_mem(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        rb = rd_cnt; wb = wr_cnt; fb = fin_cnt;
        do_drop(3'd7, 1'b1, a);
        wait_fin("t6", fb);
`ifdef DROP_COL_CHECK_EN
        chk("t6_reads", rd_cnt - rb, 0);
        chk("t6_writes", wr_cnt - wb, 0);
        chk("t6_latency", fin_cyc - a, 1);
        chk("t6_col_full", {31'b0, fin_full}, 1);
`else
        chk("t6_reads", rd_cnt - rb, 1);
        chk("t6_writes", wr_cnt - wb, 1);
        chk("t6_wr_val", {16'b0, wr_val}, 32'h8000);
        chk("t6_latency", fin_cyc - a, 4);
        chk("t6_col_full", {31'b0, fin_full}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
